// File: rtl/dense_argmax_seq.sv
// Sequential dense layer + argmax: streams one feature per cycle into N_OUT signed MACs,
// then scans the accumulators for the maximum and reports a tie mask plus the lowest winner.
module dense_argmax_seq #(
  parameter int unsigned N_IN  = 20,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned IN_W  = 6,
  parameter int unsigned W_W   = 4,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 15,
  localparam int unsigned WA_W  = $clog2(N_OUT * N_IN),
  localparam int unsigned BA_W  = $clog2(N_OUT),
  localparam int unsigned IDX_W = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wt_we,
  input  logic [WA_W-1:0]   wt_addr,
  input  logic [W_W-1:0]    wt_data,
  input  logic              b_we,
  input  logic [BA_W-1:0]   b_addr,
  input  logic [B_W-1:0]    b_data,
  output logic              cfg_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_mask,
  output logic [BA_W-1:0]   out_class
);

  localparam int unsigned P_W = IN_W + W_W + 1;

  typedef enum logic [1:0] {StAcc, StMax, StMask, StOut} state_e;

  state_e state_q, state_d;

  logic signed [W_W-1:0]   w_q   [N_OUT*N_IN];
  logic signed [B_W-1:0]   b_q   [N_OUT];
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [P_W-1:0]   prod  [N_OUT];
  logic signed [ACC_W-1:0] prod_ext [N_OUT];

  logic [IDX_W-1:0]        idx_q;
  logic [BA_W-1:0]         scan_q;
  logic signed [ACC_W-1:0] max_q;
  logic [BA_W-1:0]         arg_q;

  logic accept, idx_last, scan_last, cfg_wr_ok, wt_in_range, b_in_range;

  assign in_ready    = (state_q == StAcc);
  assign cfg_busy    = (state_q != StAcc) || (idx_q != '0);
  assign accept      = in_valid && in_ready;
  assign idx_last    = (idx_q == IDX_W'(N_IN - 1));
  assign scan_last   = (scan_q == BA_W'(N_OUT - 1));
  // The first accept of a frame makes the layer busy, so a write in that cycle is dropped too.
  assign cfg_wr_ok   = !cfg_busy && !accept;
  assign wt_in_range = ({1'b0, wt_addr} < (WA_W + 1)'(N_OUT * N_IN));
  assign b_in_range  = ({1'b0, b_addr} < (BA_W + 1)'(N_OUT));

  // Feature is zero-extended so it multiplies as a non-negative signed operand.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      prod[k]     = w_q[WA_W'(k * N_IN) + WA_W'(idx_q)] * $signed({1'b0, in_data});
      prod_ext[k] = ACC_W'(prod[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:  if (accept && idx_last) state_d = StMax;
      StMax:  if (scan_last) state_d = StMask;
      StMask: state_d = StOut;
      StOut:  if (out_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StAcc;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT * N_IN; i++) w_q[i] <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        b_q[k]   <= '0;
        acc_q[k] <= '0;
      end
      idx_q     <= '0;
      scan_q    <= '0;
      max_q     <= '0;
      arg_q     <= '0;
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_class <= '0;
    end else begin
      if (cfg_wr_ok && wt_we && wt_in_range) w_q[wt_addr] <= wt_data;
      if (cfg_wr_ok && b_we && b_in_range)   b_q[b_addr]  <= b_data;

      unique case (state_q)
        StAcc: begin
          if (accept) begin
            for (int k = 0; k < N_OUT; k++) begin
              acc_q[k] <= ((idx_q == '0) ? ACC_W'(b_q[k]) : acc_q[k]) + prod_ext[k];
            end
            idx_q <= idx_last ? '0 : idx_q + 1'b1;
          end
        end
        StMax: begin
          if (scan_q == '0) begin
            max_q <= acc_q[0];
            arg_q <= '0;
          end else if (acc_q[scan_q] > max_q) begin
            max_q <= acc_q[scan_q];
            arg_q <= scan_q;
          end
          scan_q <= scan_last ? '0 : scan_q + 1'b1;
        end
        StMask: begin
          for (int k = 0; k < N_OUT; k++) out_mask[k] <= (acc_q[k] == max_q);
          out_class <= arg_q;
          out_valid <= 1'b1;
        end
        StOut: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_argmax_seq.sv
// Bench for dense_argmax_seq: two instances (15- and 13-bit accumulators) driven identically and
// checked against an arithmetic model of the layer, plus hand-computed literal expectations.
module tb_dense_argmax_seq;

  localparam int N_IN  = 20;
  localparam int N_OUT = 10;
  localparam int IN_W  = 6;
  localparam int W_W   = 4;
  localparam int B_W   = 8;
  localparam int WA_W  = $clog2(N_OUT * N_IN);
  localparam int BA_W  = $clog2(N_OUT);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wt_we = 1'b0;
  logic [WA_W-1:0]   wt_addr = '0;
  logic [W_W-1:0]    wt_data = '0;
  logic              b_we = 1'b0;
  logic [BA_W-1:0]   b_addr = '0;
  logic [B_W-1:0]    b_data = '0;
  logic              in_valid = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              out_ready = 1'b0;

  logic              cfg_busy, in_ready, out_valid;
  logic [N_OUT-1:0]  out_mask;
  logic [BA_W-1:0]   out_class;
  logic              b13_busy, b13_ready, o13_valid;
  logic [N_OUT-1:0]  o13_mask;
  logic [BA_W-1:0]   o13_class;

  always #5 clk = ~clk;

  dense_argmax_seq #(.ACC_W(15)) u15 (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_class(out_class)
  );

  dense_argmax_seq #(.ACC_W(13)) u13 (
    .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .cfg_busy(b13_busy),
    .in_valid(in_valid), .in_ready(b13_ready), .in_data(in_data),
    .out_valid(o13_valid), .out_ready(out_ready), .out_mask(o13_mask), .out_class(o13_class)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state of the layer
  int w_m [N_OUT][N_IN];
  int b_m [N_OUT];
  int feat_m [N_IN];

  bit               exp_ok = 1'b0;
  logic [N_OUT-1:0] exp_m15, exp_m13, seen_m15, seen_m13;
  int               exp_c15, exp_c13, seen_c15, seen_c13;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint acc_val(input int accw, input int k);
    longint s, m;
    s = b_m[k];
    for (int i = 0; i < N_IN; i++) s += longint'(w_m[k][i]) * feat_m[i];
    m = longint'(1) << accw;
    s = s % m;
    if (s < 0) s += m;
    if (s >= m / 2) s -= m;
    return s;
  endfunction

  task automatic model_eval(input int accw, output logic [N_OUT-1:0] m, output int cls);
    longint v [N_OUT];
    longint mx;
    for (int k = 0; k < N_OUT; k++) v[k] = acc_val(accw, k);
    mx = v[0];
    for (int k = 1; k < N_OUT; k++) if (v[k] > mx) mx = v[k];
    cls = -1;
    for (int k = 0; k < N_OUT; k++) begin
      m[k] = (v[k] == mx);
      if (m[k] && cls < 0) cls = k;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N_OUT; k++) begin
      b_m[k] = 0;
      for (int i = 0; i < N_IN; i++) w_m[k][i] = 0;
    end
  endtask

  // Checks every cycle a result is presented, including while it is held un-taken.
  always @(negedge clk) begin
    if (!rst && exp_ok && out_valid) begin
      chk("mask15", out_mask, exp_m15);
      chk("class15", out_class, exp_c15);
      chk("valid13", o13_valid, 1);
      chk("mask13", o13_mask, exp_m13);
      chk("class13", o13_class, exp_c13);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_class", out_class, 0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input bit ww, input int k, input int i, input int wv,
                           input bit bw, input int bk, input int bv);
    wt_we = ww; wt_addr = WA_W'(k * N_IN + i); wt_data = W_W'(wv);
    b_we = bw;  b_addr = BA_W'(bk);            b_data = B_W'(bv);
    @(negedge clk);
    wt_we = 1'b0; b_we = 1'b0;
    if (ww) w_m[k][i] = wv;
    if (bw) b_m[bk] = bv;
  endtask

  // drop_at: feature index before which an un-honoured weight write is attempted.
  // collide: attempt a weight write (w[0][0]=7) together with the first accept.
  task automatic feed_features(input int gap_max, input bit collide, input int drop_at);
    for (int i = 0; i < N_IN; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_busy", cfg_busy, (i != 0));
      end
      if (i == drop_at) begin
        wt_we = 1'b1; wt_addr = WA_W'(3 * N_IN); wt_data = W_W'(7);
        chk("busy_mid", cfg_busy, 1);
        @(negedge clk);
        wt_we = 1'b0;
      end
      chk("feed_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data = IN_W'(feat_m[i]);
      if (collide && i == 0) begin
        wt_we = 1'b1; wt_addr = '0; wt_data = W_W'(7);
      end
      @(negedge clk);
      in_valid = 1'b0;
      wt_we = 1'b0;
    end
  endtask

  task automatic run_frame(input int gap_max, input bit collide, input int drop_at);
    int t_acc, n;
    feed_features(gap_max, collide, drop_at);
    t_acc = cyc;
    model_eval(15, exp_m15, exp_c15);
    model_eval(13, exp_m13, exp_c13);
    exp_ok = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      in_valid = 1'($urandom_range(1, 0));
      in_data = IN_W'($urandom_range(63, 0));
      out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
    end else begin
      chk("latency", cyc - t_acc, N_OUT + 1);
      seen_m15 = out_mask; seen_c15 = out_class;
      seen_m13 = o13_mask; seen_c13 = o13_class;
      repeat ($urandom_range(3, 0)) begin
        chk("hold_busy", cfg_busy, 1);
        chk("hold_ready", in_ready, 0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("taken_valid", out_valid, 0);
      chk("taken_ready", in_ready, 1);
      chk("taken_busy", cfg_busy, 0);
    end
    exp_ok = 1'b0;
  endtask

  task automatic fill_feats(input int v);
    for (int i = 0; i < N_IN; i++) feat_m[i] = v;
  endtask

  task automatic rand_feats();
    for (int i = 0; i < N_IN; i++) feat_m[i] = $urandom_range(63, 0);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Zero weights and biases: every class ties at zero.
    fill_feats(63);
    run_frame(0, 0, -1);
    chk("t1_mask", seen_m15, 10'h3FF);
    chk("t1_class", seen_c15, 0);

    do_reset();
    for (int i = 0; i < N_IN; i++) cfg_write(1, 3, i, 1, 0, 0, 0);
    fill_feats(5);
    chk("t2_acc3_model", acc_val(15, 3), 100);
    run_frame(1, 0, -1);
    chk("t2_mask", seen_m15, 10'h008);
    chk("t2_class", seen_c15, 3);

    do_reset();
    cfg_write(0, 0, 0, 0, 1, 7, 4);
    cfg_write(0, 0, 0, 0, 1, 2, 4);
    rand_feats();
    run_frame(1, 0, -1);
    chk("t3_mask", seen_m15, 10'h084);
    chk("t3_class", seen_c15, 2);

    // -8*63*20 = -10080 fits 15 bits; in 13 bits it wraps to -1888, and 8820 to 628.
    do_reset();
    for (int i = 0; i < N_IN; i++) cfg_write(1, 0, i, -8, 0, 0, 0);
    for (int i = 0; i < N_IN; i++) cfg_write(1, 1, i, 7, 0, 0, 0);
    fill_feats(63);
    chk("t4_acc0_15", acc_val(15, 0), -10080);
    chk("t4_acc1_15", acc_val(15, 1), 8820);
    chk("t4_acc0_13", acc_val(13, 0), -1888);
    chk("t4_acc1_13", acc_val(13, 1), 628);
    run_frame(0, 0, -1);
    chk("t4_mask15", seen_m15, 10'h002);
    chk("t4_class15", seen_c15, 1);
    chk("t4_mask13", seen_m13, 10'h002);
    chk("t4_class13", seen_c13, 1);

    // Mid-frame write is dropped; the same write after the handshake takes effect.
    do_reset();
    rand_feats();
    run_frame(1, 0, 5);
    rand_feats();
    run_frame(0, 0, -1);
    chk("t5_nowrite_mask", seen_m15, 10'h3FF);
    cfg_write(1, 3, 0, 7, 0, 0, 0);
    rand_feats();
    feat_m[0] = 10;
    run_frame(0, 0, -1);
    chk("t5_write_mask", seen_m15, 10'h008);
    chk("t5_write_class", seen_c15, 3);

    // Write alongside the first accept is dropped, seen on the following frame.
    do_reset();
    rand_feats();
    run_frame(0, 1, -1);
    rand_feats();
    feat_m[0] = 20;
    run_frame(0, 0, -1);
    chk("t6_collide_mask", seen_m15, 10'h3FF);

    // Reset in the middle of the scan aborts and clears everything.
    cfg_write(1, 4, 2, 5, 1, 6, 50);
    rand_feats();
    feed_features(0, 0, -1);
    repeat (3) @(negedge clk);
    chk("t7_scan_busy", cfg_busy, 1);
    do_reset();
    rand_feats();
    run_frame(0, 0, -1);
    chk("t7_post_rst_mask", seen_m15, 10'h3FF);
    chk("t7_post_rst_class", seen_c15, 0);

    // Randomized frames: random (often simultaneous) weight/bias writes, features and gaps.
    for (int f = 0; f < 12; f++) begin
      if (f == 6) do_reset();
      repeat ($urandom_range(40, 0)) begin
        cfg_write(1'($urandom_range(1, 0)), $urandom_range(N_OUT - 1, 0),
                  $urandom_range(N_IN - 1, 0), int'($urandom_range(15, 0)) - 8,
                  1'($urandom_range(1, 0)), $urandom_range(N_OUT - 1, 0),
                  int'($urandom_range(255, 0)) - 128);
      end
      rand_feats();
      run_frame(2, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
